// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_pkg;

  // Controller states: normal streaming, or draining after a flush request.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Number of entries in the skid buffer and width of its pointers.
  localparam int SKID_DEPTH = 3;
  localparam int PTR_W      = 2;

  // Advance a skid pointer, wrapping from the last entry back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Pulls words out of a synchronous-read FIFO and presents them as a
// valid/ready stream through a 3-entry skid buffer, with flush support.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_buf_empty,
  output logic              o_r_en,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_count
);

  state_t            state_q;
  state_t            state_d;

  logic [1:0]        occ_q;
  logic              infl_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] skid_mem [SKID_DEPTH];

  logic [2:0]        fill;
  logic              wr;
  logic              xfer;

  // Words already buffered plus the one possibly still in the FIFO read
  // pipeline; a new read is only issued when all of them are guaranteed a slot.
  assign fill = {1'b0, occ_q} + {2'b00, infl_q};

  // A landing word is stored, and a stream transfer happens, only in a RUN
  // cycle without a flush request; flush wins over both.
  assign wr   = (state_q == RUN) && infl_q && !i_flush;
  assign xfer = o_valid && i_ready && !i_flush;

  // Head of the skid buffer is driven straight from registered storage.
  assign o_data  = skid_mem[head_q];
  assign o_count = cnt_q;

  // Next-state and control outputs; reset also masks the FIFO read so no
  // word is popped while the reader is held in reset.
  always_comb begin
    state_d = state_q;
    o_r_en  = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      RUN: begin
        o_r_en  = !i_rst && !i_buf_empty && (fill < 3'(SKID_DEPTH));
        o_valid = (occ_q != 2'd0);
        if (i_flush) state_d = FLUSH;
      end
      FLUSH: begin
        o_busy = 1'b1;
        if (!infl_q && !i_flush) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Skid buffer storage, pointers, occupancy, in-flight flag and transfer count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
    end else begin
      infl_q <= o_r_en;
      if ((state_q == RUN && i_flush) || state_q == FLUSH) begin
        // Drop everything buffered; a word landing now is simply not stored.
        occ_q  <= 2'd0;
        head_q <= tail_q;
      end else begin
        if (wr) begin
          skid_mem[tail_q] <= i_rdata;
          tail_q           <= ptr_inc(tail_q);
        end
        if (xfer) begin
          head_q <= ptr_inc(head_q);
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        case ({wr, xfer})
          2'b10:   occ_q <= occ_q + 2'd1;
          2'b01:   occ_q <= occ_q - 2'd1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a queue-based FIFO model feeds the reader, and the
// delivered stream is scored against the order words were queued.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_buf_empty = 1'b1;
  logic        o_r_en;
  logic [7:0]  i_rdata = 8'h00;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [7:0]  o_data;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic [15:0] o_count;

  fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_buf_empty(i_buf_empty),
    .o_r_en     (o_r_en),
    .i_rdata    (i_rdata),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] got[$];
  int         delivered;
  int         checks;
  int         passes;
  int         cyc;

  // One clock cycle: model the FIFO pop and stream acceptance seen before
  // the edge, then present popped data one cycle later.
  task automatic step();
    logic       popped;
    logic [7:0] w;
    #1;
    popped = 1'b0;
    w      = 8'h00;
    checks++;
    if (o_r_en && i_buf_empty) $display("FAIL r_en_when_empty: o_r_en=1 with i_buf_empty=1 at cycle %0d", cyc);
    else passes++;
    if (o_r_en && fifo_q.size() > 0) begin
      w      = fifo_q.pop_front();
      popped = 1'b1;
    end
    if (o_valid && i_ready && !i_flush && !i_rst) begin
      got.push_back(o_data);
      delivered++;
    end
    @(posedge clk);
    #1;
    i_rdata     = popped ? w : 8'($urandom);
    i_buf_empty = (fifo_q.size() == 0);
    cyc++;
    #1;
  endtask

  task automatic push_seq(input int n);
    for (int i = 1; i <= n; i++) fifo_q.push_back(8'(i));
    i_buf_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b0;
    fifo_q.delete();
    i_buf_empty = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    got.delete();
    delivered = 0;
    #1;
  endtask

  task automatic test_reset();
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    i_buf_empty = 1'b0;
    i_rst = 1'b1;
    step();
    checks++; if (o_r_en !== 1'b0) $display("FAIL reset_r_en: got %b want 0", o_r_en); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passes++;
    checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passes++;
    checks++; if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data); else passes++;
    checks++; if (o_count !== 16'h0000) $display("FAIL reset_count: got %h want 0000", o_count); else passes++;
    do_reset();
  endtask

  task automatic test_stream();
    int first_ren, first_vld, first_d, last_d;
    do_reset();
    push_seq(5);
    i_ready = 1'b1;
    #1;
    first_ren = -1; first_vld = -1; first_d = -1; last_d = -1;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      if (o_r_en && first_ren < 0) first_ren = c;
      if (o_valid && first_vld < 0) first_vld = c;
      if (o_valid) begin
        if (first_d < 0) first_d = c;
        last_d = c;
      end
      step();
    end
    checks++; if (got.size() != 5) $display("FAIL stream_len: got %0d words want 5", got.size()); else passes++;
    for (int i = 0; i < got.size() && i < 5; i++) begin
      checks++; if (got[i] !== 8'(i + 1)) $display("FAIL stream_word%0d: got %0d want %0d", i, got[i], i + 1); else passes++;
    end
    checks++; if (first_vld - first_ren != 2) $display("FAIL stream_latency: got %0d want 2", first_vld - first_ren); else passes++;
    checks++; if (last_d - first_d != 4) $display("FAIL stream_back_to_back: span %0d want 4", last_d - first_d); else passes++;
    checks++; if (o_count !== 16'd5) $display("FAIL stream_count: got %0d want 5", o_count); else passes++;
  endtask

  task automatic test_backpressure();
    int pulses;
    do_reset();
    push_seq(6);
    i_ready = 1'b0;
    #1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_r_en) pulses++;
      if (c >= 4) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd1)
          $display("FAIL stall_hold c%0d: valid=%b data=%0d want valid=1 data=1", c, o_valid, o_data);
        else passes++;
      end
      step();
    end
    checks++; if (pulses != 3) $display("FAIL stall_read_pulses: got %0d want 3", pulses); else passes++;
    i_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 6; c++) step();
    checks++; if (got.size() != 6) $display("FAIL stall_len: got %0d want 6", got.size()); else passes++;
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++; if (got[i] !== 8'(i + 1)) $display("FAIL stall_word%0d: got %0d want %0d", i, got[i], i + 1); else passes++;
    end
  endtask

  task automatic test_toggle();
    do_reset();
    push_seq(10);
    i_ready = 1'b0;
    for (int c = 0; c < 100 && got.size() < 10; c++) begin
      i_ready = ~i_ready;
      step();
    end
    i_ready = 1'b0;
    #1;
    checks++; if (got.size() != 10) $display("FAIL toggle_len: got %0d want 10", got.size()); else passes++;
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++; if (got[i] !== 8'(i + 1)) $display("FAIL toggle_word%0d: got %0d want %0d", i, got[i], i + 1); else passes++;
    end
    checks++; if (o_count !== 16'd10) $display("FAIL toggle_count: got %0d want 10", o_count); else passes++;
  endtask

  task automatic test_flush();
    int         busy_cycles;
    logic [7:0] exp_next;
    int         exp_left;
    do_reset();
    push_seq(8);
    i_ready = 1'b0;
    step(); step(); step();
    // Three words are outstanding (two buffered, one landing), so no new read.
    checks++; if (o_r_en !== 1'b0) $display("FAIL flush_pre_r_en: got %b want 0", o_r_en); else passes++;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", o_valid); else passes++;
    busy_cycles = 0;
    for (int c = 0; c < 10 && o_busy; c++) begin
      busy_cycles++;
      step();
    end
    checks++;
    if (busy_cycles < 1 || busy_cycles > 2) $display("FAIL flush_busy_len: got %0d want 1..2", busy_cycles);
    else passes++;
    exp_next = fifo_q[0];
    exp_left = fifo_q.size();
    i_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < exp_left; c++) step();
    checks++; if (got.size() != exp_left) $display("FAIL flush_len: got %0d want %0d", got.size(), exp_left); else passes++;
    checks++;
    if (got.size() == 0 || got[0] !== exp_next) $display("FAIL flush_next_word: got %0d want %0d", (got.size() > 0) ? got[0] : 8'hxx, exp_next);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_next;
    do_reset();
    push_seq(12);
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++; if (o_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", o_valid); else passes++;
    i_rst = 1'b1;
    step();
    checks++; if (o_r_en !== 1'b0) $display("FAIL midrst_r_en: got %b want 0", o_r_en); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_valid); else passes++;
    checks++; if (o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", o_busy); else passes++;
    checks++; if (o_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", o_data); else passes++;
    checks++; if (o_count !== 16'h0000) $display("FAIL midrst_count: got %h want 0000", o_count); else passes++;
    i_rst = 1'b0;
    got.delete();
    delivered = 0;
    exp_next = fifo_q[0];
    i_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 1; c++) step();
    checks++;
    if (got.size() == 0 || got[0] !== exp_next) $display("FAIL midrst_next_word: got %0d want %0d", (got.size() > 0) ? got[0] : 8'hxx, exp_next);
    else passes++;
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] w;
    int         mism;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = 8'($urandom);
        fifo_q.push_back(w);
        sent.push_back(w);
        i_buf_empty = 1'b0;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (o_count !== 16'(delivered)) $display("FAIL rand_count c%0d: got %0d want %0d", c, o_count, delivered);
      else passes++;
    end
    i_ready = 1'b1;
    for (int c = 0; c < 400 && got.size() < sent.size(); c++) step();
    checks++; if (got.size() != sent.size()) $display("FAIL rand_len: got %0d want %0d", got.size(), sent.size()); else passes++;
    mism = 0;
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) mism++;
    checks++; if (mism != 0) $display("FAIL rand_order: %0d words differ, want 0", mism); else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    i_ready = 1'b1;
    for (int c = 0; c < 70000 && delivered < 65535; c++) begin
      if (fifo_q.size() < 4) begin
        fifo_q.push_back(8'($urandom));
        i_buf_empty = 1'b0;
      end
      step();
      got.delete();
    end
    i_ready = 1'b0;
    #1;
    checks++; if (o_count !== 16'hFFFF) $display("FAIL wrap_max: got %h want ffff", o_count); else passes++;
    i_ready = 1'b1;
    for (int c = 0; c < 10 && delivered < 65536; c++) step();
    i_ready = 1'b0;
    #1;
    checks++; if (o_count !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", o_count); else passes++;
  endtask

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passes = 0; delivered = 0; cyc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_flush();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
